// File: rtl/bcd_mmss_timer_if.sv
// bcd_mmss_timer_if
// Groups the control inputs and display outputs of bcd_mmss_timer.
//   start/stop/clear : one-cycle control pulses (clear > stop > start)
//   isdec            : count/adjust direction, 0 up, 1 down
//   minselect/secselect : adjust selects, levels, honoured in STOP only
//   min_ten/min_one/sec_ten/sec_one : BCD display digits
//   running/done/wrap : status; wrap is a one-cycle rollover pulse
//   blank            : display blink, present only with BCD_MMSS_BLINK_EN
// master drives the controls (controller or bench); slave is the timer.
interface bcd_mmss_timer_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic       isdec;
  logic       minselect;
  logic       secselect;
  logic [3:0] min_one;
  logic [3:0] min_ten;
  logic [3:0] sec_one;
  logic [3:0] sec_ten;
  logic       running;
  logic       done;
  logic       wrap;
`ifdef BCD_MMSS_BLINK_EN
  logic       blank;
`endif

  modport master (
`ifdef BCD_MMSS_BLINK_EN
    input  blank,
`endif
    output start, stop, clear, isdec, minselect, secselect,
    input  min_one, min_ten, sec_one, sec_ten, running, done, wrap
  );

  modport slave (
`ifdef BCD_MMSS_BLINK_EN
    output blank,
`endif
    input  start, stop, clear, isdec, minselect, secselect,
    output min_one, min_ten, sec_one, sec_ten, running, done, wrap
  );
endinterface

// File: rtl/bcd_mmss_timer.sv
// bcd_mmss_timer
// Self-timed mm:ss stopwatch / countdown timer with a rate-limited manual
// adjust path, driving a 4-digit BCD display.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : bcd_mmss_timer_if.slave (controls, BCD digits, status)
// Parameters:
//   CLK_DIV : clk cycles per counted second (>=2)
//   ADJ_DIV : clk cycles per adjust step while a select is held (>=2)
//   MIN_MAX : largest minutes value (1..99)
// Optional build macro BCD_MMSS_BLINK_EN adds the bus.blank blink output.
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_STOP | idle; count held; adjust selects are honoured
// ST_RUN  | seconds prescaler runs; count steps up or down per tick
// ST_DONE | countdown reached 00:00; count frozen, done=1
module bcd_mmss_timer #(
  parameter int CLK_DIV = 100,
  parameter int ADJ_DIV = 25,
  parameter int MIN_MAX = 59
) (
  input logic            clk,
  input logic            reset,
  bcd_mmss_timer_if.slave bus
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int AW = $clog2(ADJ_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [AW-1:0] ADJ_LAST = AW'(ADJ_DIV - 1);
  localparam logic [6:0]    MMAX     = 7'(MIN_MAX);

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [6:0]    min_q, min_d;   // binary minutes, 0..MIN_MAX
  logic [5:0]    sec_q, sec_d;   // binary seconds, 0..59
  logic [PW-1:0] pre_q, pre_d;
  logic [AW-1:0] adj_q, adj_d;
  logic          wrap_q, wrap_d;

  logic          is_zero;
  logic          go;
  logic          adj_sel;
  logic          adj_step;
  logic          sec_tick;
  logic [12:0]   nxt;

  // Whole-count +/-1 with seconds carry/borrow into minutes and
  // MIN_MAX:59 <-> 00:00 wrap.
  function automatic logic [12:0] step_full(input logic [6:0] m,
                                            input logic [5:0] s,
                                            input logic       dec);
    logic [6:0] mn;
    logic [5:0] sn;
    mn = m;
    sn = s;
    if (!dec) begin
      if (s == 6'd59) begin
        sn = 6'd0;
        mn = (m == MMAX) ? 7'd0 : m + 7'd1;
      end else begin
        sn = s + 6'd1;
      end
    end else begin
      if (s == 6'd0) begin
        sn = 6'd59;
        mn = (m == 7'd0) ? MMAX : m - 7'd1;
      end else begin
        sn = s - 6'd1;
      end
    end
    return {mn, sn};
  endfunction

  assign is_zero  = (min_q == 7'd0) && (sec_q == 6'd0);
  // A countdown from 00:00 would expire immediately, so start is refused.
  assign go       = bus.start && !bus.stop && !(bus.isdec && is_zero);
  assign adj_sel  = bus.minselect || bus.secselect;
  assign adj_step = (state_q == ST_STOP) && !bus.clear && !go && adj_sel &&
                    (adj_q == ADJ_LAST);
  // A stop in the same cycle freezes the prescaler so resume continues
  // the partial second.
  assign sec_tick = (state_q == ST_RUN) && !bus.clear && !bus.stop &&
                    (pre_q == PRE_LAST);
  assign nxt      = step_full(min_q, sec_q, bus.isdec);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_STOP;
      min_q   <= '0;
      sec_q   <= '0;
      pre_q   <= '0;
      adj_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      pre_q   <= pre_d;
      adj_q   <= adj_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    pre_d   = pre_q;
    adj_d   = adj_q;
    wrap_d  = 1'b0;
    if (bus.clear) begin
      state_d = ST_STOP;
      min_d   = '0;
      sec_d   = '0;
      pre_d   = '0;
      adj_d   = '0;
    end else begin
      case (state_q)
        ST_STOP: begin
          if (go) begin
            state_d = ST_RUN;
            adj_d   = '0;
          end else if (adj_sel) begin
            adj_d = (adj_q == ADJ_LAST) ? '0 : adj_q + AW'(1);
          end else begin
            adj_d = '0;
          end
          if (adj_step) begin
            if (bus.minselect && bus.secselect) begin
              {min_d, sec_d} = nxt;
            end else if (bus.secselect) begin
              if (bus.isdec) sec_d = (sec_q == 6'd0)  ? 6'd59 : sec_q - 6'd1;
              else           sec_d = (sec_q == 6'd59) ? 6'd0  : sec_q + 6'd1;
            end else begin
              if (bus.isdec) min_d = (min_q == 7'd0) ? MMAX : min_q - 7'd1;
              else           min_d = (min_q == MMAX) ? 7'd0 : min_q + 7'd1;
            end
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            state_d = ST_STOP;
          end else if (sec_tick) begin
            pre_d = '0;
            if (bus.isdec && is_zero) begin
              // Direction flipped to down while sitting at 00:00.
              state_d = ST_DONE;
            end else begin
              {min_d, sec_d} = nxt;
              if (bus.isdec && (nxt == 13'd0)) state_d = ST_DONE;
              if (!bus.isdec && (min_q == MMAX) && (sec_q == 6'd59)) wrap_d = 1'b1;
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        ST_DONE: begin
          pre_d = '0;
          if (bus.stop) state_d = ST_STOP;
        end
        default: state_d = ST_STOP;
      endcase
    end
  end

  assign bus.min_ten = 4'(min_q / 7'd10);
  assign bus.min_one = 4'(min_q % 7'd10);
  assign bus.sec_ten = 4'(sec_q / 6'd10);
  assign bus.sec_one = 4'(sec_q % 6'd10);
  assign bus.running = (state_q == ST_RUN);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.wrap    = wrap_q;

`ifdef BCD_MMSS_BLINK_EN
  localparam int HALF    = CLK_DIV / 2;
  localparam int BLK_MAX = (HALF > 8) ? HALF : 8;
  localparam int BW      = $clog2(BLK_MAX);

  logic [BW-1:0] blk_q;
  logic          blank_q;

  // Blink period: 8 adjust steps while adjusting, CLK_DIV/2 cycles in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_q   <= '0;
      blank_q <= 1'b0;
    end else if (state_q == ST_STOP && adj_sel && !bus.clear) begin
      if (adj_step) begin
        if (blk_q == BW'(7)) begin
          blk_q   <= '0;
          blank_q <= !blank_q;
        end else begin
          blk_q <= blk_q + BW'(1);
        end
      end
    end else if (state_q == ST_DONE && !bus.clear && !bus.stop) begin
      if (blk_q == BW'(HALF - 1)) begin
        blk_q   <= '0;
        blank_q <= !blank_q;
      end else begin
        blk_q <= blk_q + BW'(1);
      end
    end else begin
      blk_q   <= '0;
      blank_q <= 1'b0;
    end
  end

  assign bus.blank = blank_q;
`endif

endmodule

// File: tb/tb_bcd_mmss_timer.sv
// Directed bench for bcd_mmss_timer with CLK_DIV=4, ADJ_DIV=3, MIN_MAX=2.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_bcd_mmss_timer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] disp;

  always #5 clk = ~clk;

  bcd_mmss_timer_if bus();

  bcd_mmss_timer #(.CLK_DIV(4), .ADJ_DIV(3), .MIN_MAX(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign disp = {bus.min_ten, bus.min_one, bus.sec_ten, bus.sec_one};

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1; @(negedge clk); bus.stop = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1; @(negedge clk); bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h want 0000", disp); end
    checks++; if ({bus.running, bus.done, bus.wrap} !== 3'b000) begin errors++; $display("FAIL reset_status got %b want 000", {bus.running, bus.done, bus.wrap}); end
    reset = 1'b1;
    cyc(2);
    checks++; if (disp !== 16'h0000 || bus.running !== 1'b0) begin errors++; $display("FAIL idle_after_reset got %h run %b want 0000 run 0", disp, bus.running); end
  endtask

  task automatic test_up_count();
    bus.isdec = 1'b0;
    pulse_start();
    checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL up_running got %b want 1", bus.running); end
    cyc(3);
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL up_before_tick got %h want 0000", disp); end
    cyc(1);
    checks++; if (disp !== 16'h0001) begin errors++; $display("FAIL up_first_tick got %h want 0001", disp); end
    cyc(58 * 4);
    checks++; if (disp !== 16'h0059) begin errors++; $display("FAIL up_0059 got %h want 0059", disp); end
    cyc(4);
    checks++; if (disp !== 16'h0100 || bus.running !== 1'b1) begin errors++; $display("FAIL up_carry got %h run %b want 0100 run 1", disp, bus.running); end
    pulse_stop();
    pulse_clear();
    checks++; if (disp !== 16'h0000 || bus.running !== 1'b0) begin errors++; $display("FAIL up_clear got %h run %b want 0000 run 0", disp, bus.running); end
  endtask

  task automatic test_adjust();
    bus.isdec = 1'b1; bus.secselect = 1'b1;
    cyc(2);
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL adj_before_step got %h want 0000", disp); end
    cyc(1);
    checks++; if (disp !== 16'h0059) begin errors++; $display("FAIL adj_sec_down_wrap got %h want 0059", disp); end
    cyc(3);
    checks++; if (disp !== 16'h0058) begin errors++; $display("FAIL adj_sec_down got %h want 0058", disp); end
    bus.secselect = 1'b0; bus.minselect = 1'b1; bus.isdec = 1'b0;
    cyc(3);
    checks++; if (disp !== 16'h0158) begin errors++; $display("FAIL adj_min_up got %h want 0158", disp); end
    cyc(3);
    checks++; if (disp !== 16'h0258) begin errors++; $display("FAIL adj_min_up2 got %h want 0258", disp); end
    cyc(3);
    checks++; if (disp !== 16'h0058) begin errors++; $display("FAIL adj_min_wrap_up got %h want 0058", disp); end
    bus.isdec = 1'b1;
    cyc(3);
    checks++; if (disp !== 16'h0258) begin errors++; $display("FAIL adj_min_wrap_down got %h want 0258", disp); end
    bus.minselect = 1'b0;
    pulse_clear();
  endtask

  task automatic test_wrap();
    bus.isdec = 1'b1; bus.minselect = 1'b1; bus.secselect = 1'b1;
    cyc(3);
    checks++; if (disp !== 16'h0259) begin errors++; $display("FAIL adj_both_down got %h want 0259", disp); end
    bus.minselect = 1'b0; bus.secselect = 1'b0; bus.isdec = 1'b0;
    pulse_start();
    cyc(3);
    checks++; if (disp !== 16'h0259 || bus.wrap !== 1'b0) begin errors++; $display("FAIL wrap_early got %h wrap %b want 0259 wrap 0", disp, bus.wrap); end
    cyc(1);
    checks++; if (disp !== 16'h0000 || bus.wrap !== 1'b1 || bus.running !== 1'b1) begin errors++; $display("FAIL wrap_tick got %h wrap %b run %b want 0000 wrap 1 run 1", disp, bus.wrap, bus.running); end
    cyc(1);
    checks++; if (bus.wrap !== 1'b0 || bus.running !== 1'b1) begin errors++; $display("FAIL wrap_pulse_len got wrap %b run %b want wrap 0 run 1", bus.wrap, bus.running); end
    pulse_stop();
    pulse_clear();
  endtask

  task automatic test_countdown();
    bus.isdec = 1'b1;
    pulse_start();
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL down_start_at_zero got run %b want 0", bus.running); end
    bus.isdec = 1'b0; bus.secselect = 1'b1;
    cyc(6);
    bus.secselect = 1'b0;
    checks++; if (disp !== 16'h0002) begin errors++; $display("FAIL down_preset got %h want 0002", disp); end
    bus.isdec = 1'b1;
    pulse_start();
    cyc(4);
    checks++; if (disp !== 16'h0001 || bus.done !== 1'b0) begin errors++; $display("FAIL down_first got %h done %b want 0001 done 0", disp, bus.done); end
    cyc(3);
    checks++; if (bus.done !== 1'b0 || bus.running !== 1'b1) begin errors++; $display("FAIL down_before_done got done %b run %b want 0 1", bus.done, bus.running); end
    cyc(1);
    checks++; if (disp !== 16'h0000 || bus.done !== 1'b1 || bus.running !== 1'b0) begin errors++; $display("FAIL down_done got %h done %b run %b want 0000 1 0", disp, bus.done, bus.running); end
    cyc(8);
    pulse_start();
    checks++; if (disp !== 16'h0000 || bus.done !== 1'b1) begin errors++; $display("FAIL done_hold got %h done %b want 0000 done 1", disp, bus.done); end
    pulse_stop();
    checks++; if (disp !== 16'h0000 || bus.done !== 1'b0 || bus.running !== 1'b0) begin errors++; $display("FAIL done_stop got %h done %b run %b want 0000 0 0", disp, bus.done, bus.running); end
  endtask

  task automatic test_resume();
    bus.isdec = 1'b0; bus.secselect = 1'b1;
    cyc(90);
    bus.secselect = 1'b0;
    checks++; if (disp !== 16'h0030) begin errors++; $display("FAIL resume_preset got %h want 0030", disp); end
    pulse_start();
    cyc(2);
    pulse_stop();
    cyc(5);
    checks++; if (disp !== 16'h0030 || bus.running !== 1'b0) begin errors++; $display("FAIL resume_stopped got %h run %b want 0030 0", disp, bus.running); end
    pulse_start();
    cyc(1);
    checks++; if (disp !== 16'h0030) begin errors++; $display("FAIL resume_early got %h want 0030", disp); end
    cyc(1);
    checks++; if (disp !== 16'h0031) begin errors++; $display("FAIL resume_partial got %h want 0031", disp); end
    bus.clear = 1'b1; bus.stop = 1'b1; bus.start = 1'b1;
    cyc(1);
    bus.clear = 1'b0; bus.stop = 1'b0; bus.start = 1'b0;
    checks++; if (disp !== 16'h0000 || bus.running !== 1'b0) begin errors++; $display("FAIL ctl_priority got %h run %b want 0000 0", disp, bus.running); end
    cyc(6);
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL ctl_priority_idle got %h want 0000", disp); end
  endtask

  task automatic test_async_reset();
    bus.isdec = 1'b0; bus.minselect = 1'b1;
    cyc(3);
    bus.minselect = 1'b0; bus.secselect = 1'b1;
    cyc(69);
    bus.secselect = 1'b0;
    pulse_start();
    cyc(1);
    checks++; if (disp !== 16'h0123 || bus.running !== 1'b1) begin errors++; $display("FAIL rst_preset got %h run %b want 0123 1", disp, bus.running); end
    #2 reset = 1'b0;
    #1;
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL async_rst_digits got %h want 0000", disp); end
    checks++; if ({bus.running, bus.done, bus.wrap} !== 3'b000) begin errors++; $display("FAIL async_rst_status got %b want 000", {bus.running, bus.done, bus.wrap}); end
    @(negedge clk);
    reset = 1'b1;
    cyc(2);
    checks++; if (disp !== 16'h0000 || bus.running !== 1'b0) begin errors++; $display("FAIL post_rst got %h run %b want 0000 0", disp, bus.running); end
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
    bus.isdec = 1'b0; bus.minselect = 1'b0; bus.secselect = 1'b0;
    test_reset();
    test_up_count();
    test_adjust();
    test_wrap();
    test_countdown();
    test_resume();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
